lif_neuron_array: RTL and testbench



---
 rtl/lif_neuron_array_if.sv | 33 +++
 rtl/lif_neuron_array.sv | 178 +++++++++++++++++
 tb/tb_lif_neuron_array.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lif_neuron_array_if.sv
`default_nettype none
// lif_neuron_array_if : sweep control, current/spike streams and config port of lif_neuron_array (rev 1.0)
interface lif_neuron_array_if #(
  parameter int WIDTH       = 16,
  parameter int NUM_NEURONS = 8
);
  localparam int IDX_W = $clog2(NUM_NEURONS);

  logic                     step;
  logic                     busy;
  logic                     sweep_done;
  logic                     cur_valid;
  logic                     cur_ready;
  logic signed [WIDTH-1:0]  cur_data;
  logic [IDX_W-1:0]         cur_idx;
  logic                     spike_valid;
  logic                     spike_ready;
  logic [IDX_W-1:0]         spike_idx;
  logic                     cfg_we;
  logic [2:0]               cfg_addr;
  logic [WIDTH-1:0]         cfg_wdata;

  modport master (
    output step, cur_valid, cur_data, spike_ready, cfg_we, cfg_addr, cfg_wdata,
    input  busy, sweep_done, cur_ready, cur_idx, spike_valid, spike_idx
  );

  modport slave (
    input  step, cur_valid, cur_data, spike_ready, cfg_we, cfg_addr, cfg_wdata,
    output busy, sweep_done, cur_ready, cur_idx, spike_valid, spike_idx
  );
endinterface
`default_nettype wire

// File: rtl/lif_neuron_array.sv
`default_nettype none
// lif_neuron_array : time-multiplexed leaky integrate-and-fire neuron array (rev 1.0)
module lif_neuron_array #(
  parameter int WIDTH       = 16,
  parameter int NUM_NEURONS = 8,
  parameter int REFR_W      = 8
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  lif_neuron_array_if.slave bus
);
  localparam int                      IDX_W    = $clog2(NUM_NEURONS);
  localparam int                      EXT_W    = WIDTH + 2;
  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_NEURONS - 1);
  localparam logic signed [WIDTH-1:0] DEF_THR  = WIDTH'(30000);
  localparam logic signed [WIDTH-1:0] DEF_LEAK = WIDTH'(100);
  localparam logic [REFR_W-1:0]       DEF_REFR = REFR_W'(10);
  localparam logic signed [WIDTH-1:0] DEF_VMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] DEF_VMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;

  logic signed [WIDTH-1:0] vmem_q [NUM_NEURONS];
  logic [REFR_W-1:0]       refr_q [NUM_NEURONS];

  logic signed [WIDTH-1:0] thr_q;
  logic signed [WIDTH-1:0] leak_q;
  logic [REFR_W-1:0]       refr_per_q;
  logic signed [WIDTH-1:0] vmax_q;
  logic signed [WIDTH-1:0] vmin_q;
  logic signed [WIDTH-1:0] vreset_q;
  logic                    leak_mode_q;

  logic                    spike_valid_q;
  logic [IDX_W-1:0]        spike_idx_q;

  logic                    cur_ready;
  logic                    cur_hs;
  logic signed [WIDTH-1:0] v_cur;
  logic signed [WIDTH-1:0] leak_amt;
  logic signed [EXT_W-1:0] v_sum;
  logic signed [WIDTH-1:0] v_clamp;
  logic                    in_refr;
  logic                    fire;
  logic                    cfg_ok;
  logic signed [WIDTH-1:0] cfg_sdata;

  function automatic logic signed [EXT_W-1:0] sext(input logic signed [WIDTH-1:0] v);
    return {{2{v[WIDTH-1]}}, v};
  endfunction

  // A pending spike owns the output slot; the sweep waits rather than drop it.
  assign cur_ready = (state_q == S_SWEEP) && (!spike_valid_q || bus.spike_ready);
  assign cur_hs    = bus.cur_valid && cur_ready;

  assign bus.cur_ready   = cur_ready;
  assign bus.cur_idx     = idx_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.sweep_done  = (state_q == S_DONE);
  assign bus.spike_valid = spike_valid_q;
  assign bus.spike_idx   = spike_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (bus.step) begin
          state_d = S_SWEEP;
          idx_d   = '0;
        end
      end
      S_SWEEP: begin
        if (cur_hs) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Integration is carried two bits wider so the clamp sees true overflow.
  always_comb begin
    v_cur    = vmem_q[idx_q];
    in_refr  = (refr_q[idx_q] != '0);
    leak_amt = leak_mode_q ? (v_cur >>> leak_q[3:0]) : leak_q;
    v_sum    = sext(v_cur) + sext(bus.cur_data) - sext(leak_amt);
    if (v_sum > sext(vmax_q)) begin
      v_clamp = vmax_q;
    end else if (v_sum < sext(vmin_q)) begin
      v_clamp = vmin_q;
    end else begin
      v_clamp = v_sum[WIDTH-1:0];
    end
    fire = !in_refr && (v_clamp >= thr_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        vmem_q[i] <= '0;
        refr_q[i] <= '0;
      end
    end else if (cur_hs) begin
      if (in_refr) begin
        refr_q[idx_q] <= refr_q[idx_q] - 1'b1;
      end else if (fire) begin
        vmem_q[idx_q] <= vreset_q;
        refr_q[idx_q] <= refr_per_q;
      end else begin
        vmem_q[idx_q] <= v_clamp;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_valid_q <= 1'b0;
      spike_idx_q   <= '0;
    end else if (cur_hs && fire) begin
      spike_valid_q <= 1'b1;
      spike_idx_q   <= idx_q;
    end else if (bus.spike_ready) begin
      spike_valid_q <= 1'b0;
    end
  end

  assign cfg_ok    = bus.cfg_we && (state_q == S_IDLE);
  assign cfg_sdata = $signed(bus.cfg_wdata);

  // Bound writes are checked against the other bound so V_max >= V_min always holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_q       <= DEF_THR;
      leak_q      <= DEF_LEAK;
      refr_per_q  <= DEF_REFR;
      vmax_q      <= DEF_VMAX;
      vmin_q      <= DEF_VMIN;
      vreset_q    <= '0;
      leak_mode_q <= 1'b0;
    end else if (cfg_ok) begin
      case (bus.cfg_addr)
        3'd0: thr_q      <= cfg_sdata;
        3'd1: leak_q     <= cfg_sdata;
        3'd2: refr_per_q <= bus.cfg_wdata[REFR_W-1:0];
        3'd3: if (cfg_sdata >= vmin_q) vmax_q <= cfg_sdata;
        3'd4: if (vmax_q >= cfg_sdata) vmin_q <= cfg_sdata;
        3'd5: vreset_q    <= cfg_sdata;
        3'd6: leak_mode_q <= bus.cfg_wdata[0];
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_lif_neuron_array.sv
`default_nettype none
// tb_lif_neuron_array : randomized scoreboard bench against a behavioural LIF model (rev 1.0)
module tb_lif_neuron_array;
  localparam int W  = 16;
  localparam int NN = 8;
  localparam int RW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lif_neuron_array_if #(.WIDTH(W), .NUM_NEURONS(NN)) bus ();
  lif_neuron_array #(.WIDTH(W), .NUM_NEURONS(NN), .REFR_W(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int passed = 0;
  int spikes_seen = 0;
  int bp_rate = 0;
  bit hold = 1'b0;

  int m_vm[NN];
  int m_rc[NN];
  int m_thr, m_leak, m_refr, m_vmax, m_vmin, m_vres, m_mode;
  int exp_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NN; i++) begin
      m_vm[i] = 0;
      m_rc[i] = 0;
    end
    m_thr = 30000; m_leak = 100; m_refr = 10;
    m_vmax = 32767; m_vmin = -32768; m_vres = 0; m_mode = 0;
  endfunction

  // One neuron update: leak, integrate, saturate, fire.
  function automatic void model_step(input int n, input int cur);
    int lk, v;
    if (m_rc[n] > 0) begin
      m_rc[n]--;
      return;
    end
    lk = (m_mode != 0) ? (m_vm[n] >>> (m_leak & 15)) : m_leak;
    v  = m_vm[n] + cur - lk;
    if (v > m_vmax) v = m_vmax;
    if (v < m_vmin) v = m_vmin;
    if (v >= m_thr) begin
      exp_q.push_back(n);
      m_vm[n] = m_vres;
      m_rc[n] = m_refr;
    end else begin
      m_vm[n] = v;
    end
  endfunction

  function automatic void model_cfg(input int addr, input logic [15:0] d);
    int s;
    s = int'($signed(d));
    case (addr)
      0: m_thr  = s;
      1: m_leak = s;
      2: m_refr = int'(d[7:0]);
      3: if (s >= m_vmin) m_vmax = s;
      4: if (m_vmax >= s) m_vmin = s;
      5: m_vres = s;
      6: m_mode = int'(d[0]);
      default: ;
    endcase
  endfunction

  task automatic cfg_write(input int addr, input logic [15:0] d, input bit applies);
    @(posedge clk); #1;
    bus.cfg_we = 1'b1; bus.cfg_addr = 3'(addr); bus.cfg_wdata = d;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    if (applies) model_cfg(addr, d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; bus.cur_valid = 1'b0; bus.step = 1'b0; bus.cfg_we = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    exp_q.delete();
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < NN; i++) begin
      check($sformatf("%s_vmem[%0d]", tag, i), dut.vmem_q[i], m_vm[i]);
      check($sformatf("%s_refr[%0d]", tag, i), dut.refr_q[i], m_rc[i]);
    end
  endtask

  task automatic do_sweep(input int cur[NN]);
    bit ok;
    @(posedge clk); #1 bus.step = 1'b1;
    @(posedge clk); #1 bus.step = 1'b0;
    for (int n = 0; n < NN; n++) begin
      bus.cur_data  = W'(cur[n]);
      bus.cur_valid = ($urandom_range(3) != 0);
      ok = 1'b0;
      for (int t = 0; t < 300 && !ok; t++) begin
        @(negedge clk);
        if (bus.cur_valid && bus.cur_ready) begin
          check("cur_idx", bus.cur_idx, n);
          model_step(n, cur[n]);
          ok = 1'b1;
        end
        @(posedge clk); #1;
        if (!ok) bus.cur_valid = 1'b1;
      end
      if (!ok) begin
        check("sweep_handshake_timeout", 0, 1);
        bus.cur_valid = 1'b0;
        return;
      end
    end
    bus.cur_valid = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (bus.sweep_done) ok = 1'b1;
    end
    check("sweep_done", ok, 1);
    @(negedge clk);
    check("sweep_done_pulse", bus.sweep_done, 0);
    check("busy_after_done", bus.busy, 0);
    check_state("sweep");
  endtask

  // Backpressure source
  initial begin
    bus.spike_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.spike_ready = hold ? 1'b0 : (int'($urandom_range(99)) >= bp_rate);
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && bus.spike_valid && bus.spike_ready) begin
      spikes_seen++;
      if (exp_q.size() == 0) check("spike_unexpected", bus.spike_idx, -1);
      else check("spike_idx", bus.spike_idx, exp_q.pop_front());
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, checks);
    $fatal(1);
  end

  initial begin
    int cur[NN];
    bit ok;
    bus.step = 1'b0; bus.cur_valid = 1'b0; bus.cur_data = '0;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    model_reset();

    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_sweep_done", bus.sweep_done, 0);
    check("rst_cur_ready", bus.cur_ready, 0);
    check("rst_spike_valid", bus.spike_valid, 0);
    check("rst_spike_idx", bus.spike_idx, 0);
    check("rst_cur_idx", bus.cur_idx, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Defaults: neuron 0 spikes on sweep 3 and 16
    spikes_seen = 0;
    for (int s = 1; s <= 16; s++) begin
      cur = '{default: 100};
      cur[0] = 10100;
      do_sweep(cur);
      if (s == 1)  check("t1_v0_s1", dut.vmem_q[0], 10000);
      if (s == 2)  check("t1_v0_s2", dut.vmem_q[0], 20000);
      if (s == 3)  check("t1_v0_s3", dut.vmem_q[0], 0);
      if (s == 13) check("t1_v0_s13", dut.vmem_q[0], 0);
      if (s == 14) check("t1_v0_s14", dut.vmem_q[0], 10000);
    end
    repeat (3) @(negedge clk);
    check("t1_spike_count", spikes_seen, 2);

    // Saturation without wrap
    do_reset();
    cfg_write(1, 16'd0, 1);
    cfg_write(0, 16'd32767, 1);
    for (int s = 0; s < 5; s++) begin
      cur = '{default: 0};
      cur[0] = (s < 2) ? -32768 : ((s < 4) ? 32767 : 1);
      do_sweep(cur);
      if (s == 1) check("sat_min", dut.vmem_q[0], -32768);
      if (s == 2) check("sat_m1", dut.vmem_q[0], -1);
      if (s == 3) check("sat_32766", dut.vmem_q[0], 32766);
    end

    // Backpressure on neuron 2 stalls the sweep
    do_reset();
    repeat (2) @(negedge clk);
    hold = 1'b1;
    cur = '{default: 0};
    cur[2] = 30100;
    fork
      do_sweep(cur);
      begin
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
          @(negedge clk);
          if (bus.spike_valid) ok = 1'b1;
        end
        check("bp_spike_seen", ok, 1);
        repeat (4) begin
          @(negedge clk);
          check("bp_valid_held", bus.spike_valid, 1);
          check("bp_spike_idx", bus.spike_idx, 2);
          check("bp_cur_ready", bus.cur_ready, 0);
          check("bp_cur_idx", bus.cur_idx, 3);
        end
        hold = 1'b0;
      end
    join

    // Shift leak
    do_reset();
    cfg_write(6, 16'd1, 1);
    cfg_write(1, 16'd2, 1);
    for (int s = 0; s < 3; s++) begin
      cur = '{default: 0};
      cur[0] = (s == 0) ? 8000 : 0;
      do_sweep(cur);
    end
    check("shift_4500", dut.vmem_q[0], 4500);

    // Config protection
    do_reset();
    cur = '{default: 500};
    fork
      do_sweep(cur);
      begin
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
          @(negedge clk);
          if (bus.busy) ok = 1'b1;
        end
        check("cfg_busy_seen", ok, 1);
        cfg_write(0, 16'd100, 0);
      end
    join
    check("cfg_thr_protected", dut.thr_q, 30000);
    cfg_write(3, 16'hFFFB, 1);
    check("cfg_vmax_accept", dut.vmax_q, -5);
    cfg_write(4, 16'd0, 1);
    check("cfg_vmin_reject", dut.vmin_q, -32768);
    cur = '{default: 3000};
    do_sweep(cur);

    // Reset mid-sweep at idx 3
    cfg_write(0, 16'd1000, 1);
    @(posedge clk); #1 bus.step = 1'b1;
    @(posedge clk); #1 bus.step = 1'b0;
    bus.cur_valid = 1'b1; bus.cur_data = '0;
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (bus.cur_idx == 3) ok = 1'b1;
      else if (bus.cur_ready) model_step(int'(bus.cur_idx), 0);
    end
    check("mid_reach_idx3", ok, 1);
    rst_n = 1'b0;
    #1;
    check("mid_busy", bus.busy, 0);
    check("mid_spike_valid", bus.spike_valid, 0);
    check("mid_cur_idx", bus.cur_idx, 0);
    check("mid_thr_default", dut.thr_q, 30000);
    check("mid_vmax_default", dut.vmax_q, 32767);
    bus.cur_valid = 1'b0;
    model_reset();
    exp_q.delete();
    check_state("mid");
    @(posedge clk); #1 rst_n = 1'b1;
    cur = '{default: 200};
    do_sweep(cur);

    // Randomized sweeps with random config and backpressure
    bp_rate = 30;
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(2) == 0) begin
        int a;
        int d;
        a = int'($urandom_range(7));
        case (a)
          0: d = int'($urandom_range(20000));
          1: d = int'($urandom_range(300));
          2: d = int'($urandom_range(3));
          3: d = int'($urandom_range(32767)) - 2000;
          4: d = -int'($urandom_range(32768));
          5: d = int'($urandom_range(2000)) - 1000;
          default: d = int'($urandom_range(1));
        endcase
        cfg_write(a, 16'(d), 1);
      end
      for (int i = 0; i < NN; i++) cur[i] = int'($urandom_range(8000)) - 2000;
      do_sweep(cur);
    end
    bp_rate = 0;
    repeat (10) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
`default_nettype wire
